// File: rtl/ram64_arbiter.sv
// Two-port round-robin controller for a 64x16 RAM64 block: clears the array after
// reset, then serialises single-word read/write transactions using req/ack handshakes.
module ram64_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [5:0]  adr0,
    input  logic [5:0]  adr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        ram_e,
    output logic        ram_w,
    output logic        ram_r,
    output logic [5:0]  ram_adr,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout
);

    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, ACK} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic        last_grant_q;
    logic        grant_q;
    logic        we_q;
    logic [5:0]  adr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        grant_d;

    // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
    assign grant_d = req1 && (!req0 || !last_grant_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_q <= IDLE;
                end
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= grant_d ? we1 : we0;
                        adr_q        <= grant_d ? adr1 : adr0;
                        wdata_q      <= grant_d ? wdata1 : wdata0;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) rdata_q <= ram_dout;
                    state_q <= ACK;
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so nothing reaches the RAM while rst is high.
    always_comb begin
        ram_e   = 1'b0;
        ram_w   = 1'b0;
        ram_r   = 1'b0;
        ram_adr = '0;
        ram_din = '0;
        busy    = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        if (!rst) begin
            case (state_q)
                CLEAR: begin
                    ram_e   = 1'b1;
                    ram_w   = 1'b1;
                    ram_adr = cnt_q;
                    ram_din = CLEAR_VALUE;
                    busy    = 1'b1;
                end
                ACCESS: begin
                    ram_e   = 1'b1;
                    ram_w   = we_q;
                    ram_r   = !we_q;
                    ram_adr = adr_q;
                    ram_din = wdata_q;
                end
                ACK: begin
                    ack0 = !grant_q;
                    ack1 = grant_q;
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Directed bench for ram64_arbiter with a behavioural RAM64 model attached to the RAM port.
module tb_ram64_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [5:0]  adr0, adr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, busy;
    logic [15:0] rdata;
    logic        ram_e, ram_w, ram_r;
    logic [5:0]  ram_adr;
    logic [15:0] ram_din, ram_dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_e && ram_w) mem[ram_adr] <= ram_din;
    always_comb ram_dout = (ram_e && ram_r) ? mem[ram_adr] : 16'h0000;

    ram64_arbiter #(.CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'hA5A5)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_e(ram_e), .ram_w(ram_w), .ram_r(ram_r),
        .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    task automatic start_req(input int port, input logic we, input logic [5:0] adr,
                             input logic [15:0] wd);
        if (port == 0) begin req0 = 1'b1; we0 = we; adr0 = adr; wdata0 = wd; end
        else           begin req1 = 1'b1; we1 = we; adr1 = adr; wdata1 = wd; end
    endtask

    task automatic release_req(input int port);
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ram_e, ram_w, ram_r, ram_adr, ram_din} !== 25'd0) begin
            n_bad++; $display("FAIL reset_ram_outputs: got %h want 0",
                              {ram_e, ram_w, ram_r, ram_adr, ram_din});
        end
        n_cmp++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ack_busy: got %b want 000", {ack0, ack1, busy});
        end
        n_cmp++;
        if (rdata !== 16'h0000) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0000", rdata);
        end
    endtask

    // Ends at the negedge of cycle 64, the first IDLE cycle.
    task automatic test_clear();
        release_reset();
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, ram_e, ram_w, ram_r} !== 4'b1110 || ram_adr !== 6'(c) ||
                ram_din !== 16'hA5A5) begin
                n_bad++;
                $display("FAIL clear_cycle%0d: busy/e/w/r=%b adr=%0d din=%h want 1110 adr=%0d din=a5a5",
                         c, {busy, ram_e, ram_w, ram_r}, ram_adr, ram_din, c);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ram_e !== 1'b0) begin
            n_bad++; $display("FAIL clear_done: busy=%b ram_e=%b want 0 0", busy, ram_e);
        end
    endtask

    task automatic test_simultaneous();
        start_req(0, 1'b1, 6'd5, 16'h0001);
        start_req(1, 1'b1, 6'd6, 16'h0002);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ack0 !== (k == 2 || k == 8) || ack1 !== (k == 5 || k == 11)) begin
                n_bad++; $display("FAIL simul_ack_k%0d: ack0=%b ack1=%b want %b %b", k, ack0, ack1,
                                  (k == 2 || k == 8), (k == 5 || k == 11));
            end
            if (k % 3 == 1) begin
                n_cmp++;
                if (ram_e !== 1'b1 || ram_adr !== ((k % 6 == 1) ? 6'd5 : 6'd6)) begin
                    n_bad++; $display("FAIL simul_grant_k%0d: ram_e=%b adr=%0d want 1 %0d", k, ram_e,
                                      ram_adr, (k % 6 == 1) ? 5 : 6);
                end
            end
            if (k == 11) begin release_req(0); release_req(1); end
        end
        n_cmp++;
        if (mem[5] !== 16'h0001 || mem[6] !== 16'h0002) begin
            n_bad++; $display("FAIL simul_mem: mem5=%h mem6=%h want 0001 0002", mem[5], mem[6]);
        end
    endtask

    task automatic test_clear_readback();
        logic [5:0] addrs [3];
        addrs[0] = 6'd0; addrs[1] = 6'd31; addrs[2] = 6'd63;
        for (int i = 0; i < 3; i++) begin
            start_req(0, 1'b0, addrs[i], 16'h0000);
            @(negedge clk);
            @(negedge clk);
            n_cmp++;
            if (ack0 !== 1'b1 || rdata !== 16'hA5A5) begin
                n_bad++; $display("FAIL readback_adr%0d: ack0=%b rdata=%h want 1 a5a5",
                                  addrs[i], ack0, rdata);
            end
            release_req(0);
            @(negedge clk);
        end
    endtask

    task automatic test_single_port();
        start_req(0, 1'b1, 6'd17, 16'h1234);
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b0 || ram_w !== 1'b1 || ram_r !== 1'b0 || ram_adr !== 6'd17 ||
            ram_din !== 16'h1234) begin
            n_bad++; $display("FAIL single_wr_access: ack0=%b w=%b r=%b adr=%0d din=%h want 0 1 0 17 1234",
                              ack0, ram_w, ram_r, ram_adr, ram_din);
        end
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || ram_e !== 1'b0) begin
            n_bad++; $display("FAIL single_wr_ack: ack0=%b ack1=%b ram_e=%b want 1 0 0",
                              ack0, ack1, ram_e);
        end
        release_req(0);
        @(negedge clk);
        start_req(0, 1'b0, 6'd17, 16'h0000);
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b0 || ram_r !== 1'b1 || ram_w !== 1'b0) begin
            n_bad++; $display("FAIL single_rd_access: ack0=%b r=%b w=%b want 0 1 0", ack0, ram_r, ram_w);
        end
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 16'h1234) begin
            n_bad++; $display("FAIL single_rd_ack: ack0=%b ack1=%b rdata=%h want 1 0 1234",
                              ack0, ack1, rdata);
        end
        release_req(0);
        @(negedge clk);
    endtask

    task automatic test_cross_port();
        start_req(1, 1'b1, 6'd63, 16'hBEEF);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
            n_bad++; $display("FAIL cross_wr_ack: ack1=%b ack0=%b want 1 0", ack1, ack0);
        end
        release_req(1);
        @(negedge clk);
        start_req(0, 1'b0, 6'd63, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || rdata !== 16'hBEEF) begin
            n_bad++; $display("FAIL cross_rd: ack0=%b rdata=%h want 1 beef", ack0, rdata);
        end
        release_req(0);
        @(negedge clk);
        start_req(1, 1'b1, 6'd10, 16'h5555);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ack1 !== 1'b1 || rdata !== 16'hBEEF) begin
            n_bad++; $display("FAIL cross_wr_hold: ack1=%b rdata=%h want 1 beef", ack1, rdata);
        end
        release_req(1);
        @(negedge clk);
        n_cmp++;
        if (rdata !== 16'hBEEF) begin
            n_bad++; $display("FAIL cross_idle_hold: rdata=%h want beef", rdata);
        end
    endtask

    // Leaves rst asserted with req1 pending so the next test sees a fresh sweep.
    task automatic test_reset_mid_op();
        start_req(0, 1'b1, 6'd9, 16'hDEAD);
        @(negedge clk);
        n_cmp++;
        if (ram_e !== 1'b1 || ram_w !== 1'b1 || ram_adr !== 6'd9) begin
            n_bad++; $display("FAIL midrst_access: e=%b w=%b adr=%0d want 1 1 9", ram_e, ram_w, ram_adr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_e, ram_w, ram_r} !== 3'b000 || ack0 !== 1'b0) begin
            n_bad++; $display("FAIL midrst_strobes: e/w/r=%b ack0=%b want 000 0", {ram_e, ram_w, ram_r}, ack0);
        end
        release_req(0);
        start_req(1, 1'b0, 6'd9, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ack0 !== 1'b0) begin
                n_bad++; $display("FAIL midrst_noack_k%0d: ack0=%b want 0", k, ack0);
            end
        end
        n_cmp++;
        if (mem[9] !== 16'hA5A5) begin
            n_bad++; $display("FAIL midrst_nowrite: mem9=%h want a5a5", mem[9]);
        end
    endtask

    task automatic test_req_during_sweep();
        release_reset();
        for (int c = 0; c <= 66; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ack0 !== 1'b0 || ack1 !== (c == 66)) begin
                n_bad++; $display("FAIL sweep_ack_c%0d: ack0=%b ack1=%b want 0 %b", c, ack0, ack1, (c == 66));
            end
            if (c < 64) begin
                n_cmp++;
                if (ram_r !== 1'b0 || ram_w !== 1'b1 || ram_adr !== 6'(c)) begin
                    n_bad++; $display("FAIL sweep_restart_c%0d: r=%b w=%b adr=%0d want 0 1 %0d",
                                      c, ram_r, ram_w, ram_adr, c);
                end
            end
            if (c == 65) begin
                n_cmp++;
                if (ram_r !== 1'b1 || ram_adr !== 6'd9) begin
                    n_bad++; $display("FAIL sweep_p1_access: r=%b adr=%0d want 1 9", ram_r, ram_adr);
                end
            end
        end
        n_cmp++;
        if (rdata !== 16'hA5A5) begin
            n_bad++; $display("FAIL sweep_p1_rdata: rdata=%h want a5a5", rdata);
        end
        release_req(1);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_simultaneous();
        test_clear_readback();
        test_single_port();
        test_cross_port();
        test_reset_mid_op();
        test_req_during_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram64_arbiter.md
# ram64_arbiter

Two-port round-robin access controller for the 64-word x 16-bit RAM64 block. It initialises the whole array to a fixed value after reset, then serialises single-word read/write transactions from two requesters onto the single RAM64 port. Each transaction uses a req/ack handshake. It sits between two bus masters (for example, a CPU and a DMA engine) and the RAM64 instance. The RAM64 instance is driven only by this block.

## Interface
- CLEAR_ON_RESET, 1: 1 = run the 64-word clear sweep after reset; 0 = go straight to IDLE.
- CLEAR_VALUE, 16'h0000: data word written to every address during the clear sweep.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0, req1  in  1  transaction request from port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read; held stable while req is high.
- adr0, adr1  in  6  word address; held stable while req is high.
- wdata0, wdata1  in  16  write data; held stable while req is high.
- ack0, ack1  out  1  one-cycle completion pulse for port 0 / port 1.
- rdata  out  16  read data, shared by both ports; valid in the ack cycle of a read.
- busy  out  1  high while the clear sweep runs.
- ram_e, ram_w, ram_r  out  1  RAM64 enable, write, and read strobes.
- ram_adr  out  6  RAM64 address.
- ram_din  out  16  RAM64 write data.
- ram_dout  in  16  RAM64 read data; valid combinationally while ram_e and ram_r are high.

## Operation
- The FSM has four states: CLEAR, IDLE, ACCESS, ACK.
- Reset values:
  - State = CLEAR (or IDLE when CLEAR_ON_RESET = 0); clear counter = 0; last_grant = 1, so port 0 wins the first tie.
  - rdata = 0; ack0 = ack1 = 0.
  - ram_e, ram_w, ram_r, ram_adr, ram_din are all 0 while rst is high. All RAM outputs are gated by !rst, so no RAM write happens during reset.
- CLEAR:
  - Outputs: ram_e = 1, ram_w = 1, ram_r = 0, ram_adr = counter, ram_din = CLEAR_VALUE, busy = 1.
  - The counter increments every cycle. After the cycle with counter = 63, the FSM goes to IDLE.
  - Requests are ignored but remain pending; requesters keep req high.
- IDLE:
  - RAM outputs are all 0.
  - When any req is sampled high, the winner's we, adr and wdata are latched and the FSM goes to ACCESS.
  - If only one port requests, that port wins.
  - If both request, the port that is not last_grant wins. last_grant updates to the winner.
- ACCESS:
  - Outputs: ram_e = 1, ram_w = latched we, ram_r = !latched we, ram_adr = latched adr, ram_din = latched wdata.
  - The RAM write commits on the edge that ends ACCESS.
  - For a read, rdata captures ram_dout on that same edge.
  - The FSM then goes to ACK.
- ACK:
  - The winner's ack is high for exactly this cycle; RAM outputs are all 0.
  - The FSM returns to IDLE.
  - The requester lowers req on the edge that ends ACK. A req still sampled high in IDLE counts as a new transaction.
- rdata holds its value until the next read completes. Writes never change rdata.
- A request from the losing port stays pending and wins the next IDLE slot; it cannot starve.
- The same port never receives two consecutive grants while the other port is requesting.
- Reset asserted mid-transaction: the transaction is abandoned and no ack is issued. Reset asserted mid-clear: the sweep restarts from address 0.

## Timing
- Clear sweep: 64 cycles (cycle 0 to cycle 63 after reset release). The first IDLE cycle is cycle 64. busy falls at the start of cycle 64.
- Transaction latency: req sampled in IDLE at cycle n → ACCESS in cycle n+1 → ack high in cycle n+2, with rdata valid in that same cycle.
- Throughput: one transaction per 3 cycles. Two continuously requesting ports alternate, with 3 cycles per grant.
- The RAM port is idle (ram_e = 0) in every IDLE and ACK cycle. ram_w and ram_r are never both high.
- The two acks are never high at the same time.

## Test plan
- Clear check:
  - Stimulus: CLEAR_ON_RESET = 1, CLEAR_VALUE = 16'hA5A5; release reset.
  - Response: busy high for exactly 64 cycles; ram_adr steps 0..63 with ram_w = 1.
  - Then read addresses 0, 31 and 63 through port 0: each ack returns rdata = 16'hA5A5.
- Single-port write/read:
  - Stimulus: port 0 writes 16'h1234 to address 6'd17, then reads address 6'd17.
  - Response: ack0 two cycles after each req is sampled; the read returns rdata = 16'h1234; ack1 stays 0.
- Simultaneous requests:
  - Stimulus: after the clear, req0 and req1 both go high in the same cycle and stay high for 4 transactions; port 0 writes 16'h0001 to address 6'd5, port 1 writes 16'h0002 to address 6'd6.
  - Response: grant order is 0, 1, 0, 1; acks are spaced 3 cycles apart.
- Write/read across ports:
  - Stimulus: port 1 writes 16'hBEEF to address 6'd63; port 0 then reads address 6'd63.
  - Response: rdata = 16'hBEEF in the ack0 cycle.
  - Stimulus: a port 1 write follows.
  - Response: rdata stays 16'hBEEF.
- Reset mid-operation:
  - Stimulus: assert rst during an ACCESS cycle of a port 0 write to address 6'd9.
  - Response: no ack0 is issued; all RAM strobes go 0 immediately; the clear sweep restarts at address 0.
- Requests during the sweep:
  - Stimulus: hold req1 high throughout the clear sweep.
  - Response: no RAM access for port 1 before cycle 64; ack1 is high in cycle 66.
